coinc_counter_bank: RTL and testbench

//  Responder side of the coinc read bus: counts detector pulses on two channels (A, B)
//  and their A/B coincidences within a time window. Snapshots counts on ocx and clears

---
 rtl/coinc_counter_bank.sv | 194 +++++++++++++++++++
 tb/tb_coinc_counter_bank.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coinc_counter_bank.sv
// Coincidence counter bank: counts pulses on channels A and B plus their windowed A/B
// coincidences, with snapshot/clear strobes and a registered word-wide read port.
module coinc_counter_bank #(
  parameter int unsigned DW  = 16,
  parameter int unsigned WIN = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PA,
  input  logic          PB,
  input  logic          cea,
  input  logic          ceb,
  input  logic          bh,
  input  logic          bl,
  input  logic          ocx,
  input  logic          ocy,
  output logic [DW-1:0] DX,
  output logic          dv,
  output logic [2:0]    ovf
);

  localparam int unsigned   CW      = 2 * DW;
  localparam logic [3:0]    WinLast = 4'(WIN - 1);
  localparam logic [CW-1:0] CntOne  = {{(CW - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StAOpen, StBOpen} win_state_e;

  // Two synchroniser stages plus one history stage for rising-edge detection.
  logic [2:0] pa_sync_q, pb_sync_q;
  logic       edge_a, edge_b;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pa_sync_q <= '0;
      pb_sync_q <= '0;
    end else begin
      pa_sync_q <= {pa_sync_q[1:0], PA};
      pb_sync_q <= {pb_sync_q[1:0], PB};
    end
  end

  assign edge_a = pa_sync_q[1] & ~pa_sync_q[2];
  assign edge_b = pb_sync_q[1] & ~pb_sync_q[2];

  win_state_e state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic       inc_c;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    inc_c   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (edge_a && edge_b) begin
          inc_c = 1'b1;
        end else if (edge_a) begin
          state_d = StAOpen;
          wcnt_d  = WinLast;
        end else if (edge_b) begin
          state_d = StBOpen;
          wcnt_d  = WinLast;
        end
      end
      StAOpen: begin
        if (edge_b) begin
          inc_c   = 1'b1;
          state_d = StIdle;
        end else if (edge_a) begin
          wcnt_d = WinLast;
        end else if (wcnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StBOpen: begin
        if (edge_a) begin
          inc_c   = 1'b1;
          state_d = StIdle;
        end else if (edge_b) begin
          wcnt_d = WinLast;
        end else if (wcnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (ocy) begin
      state_d = StIdle;
      wcnt_d  = '0;
      inc_c   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_c_q, cnt_c_d;
  logic [2:0]    ovf_q, ovf_d;

  // Clear takes priority: a pulse landing on the clear edge is dropped.
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    cnt_c_d = cnt_c_q;
    ovf_d   = ovf_q;
    if (ocy) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
      cnt_c_d = '0;
      ovf_d   = '0;
    end else begin
      if (edge_a) begin
        cnt_a_d = cnt_a_q + CntOne;
        if (&cnt_a_q) ovf_d[0] = 1'b1;
      end
      if (edge_b) begin
        cnt_b_d = cnt_b_q + CntOne;
        if (&cnt_b_q) ovf_d[1] = 1'b1;
      end
      if (inc_c) begin
        cnt_c_d = cnt_c_q + CntOne;
        if (&cnt_c_q) ovf_d[2] = 1'b1;
      end
    end
  end

  logic [CW-1:0] sh_a_q, sh_b_q, sh_c_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
      ovf_q   <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_c_q  <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
      ovf_q   <= ovf_d;
      if (ocx) begin
        sh_a_q <= cnt_a_q;
        sh_b_q <= cnt_b_q;
        sh_c_q <= cnt_c_q;
      end
    end
  end

  logic          rd_req;
  logic [CW-1:0] rd_cnt;
  logic [DW-1:0] dx_d, dx_q;
  logic          dv_q;

  always_comb begin
    rd_req = (cea | ceb) & (bh ^ bl);
    if (cea && ceb) begin
      rd_cnt = sh_c_q;
    end else if (cea) begin
      rd_cnt = sh_a_q;
    end else begin
      rd_cnt = sh_b_q;
    end
    dx_d = '0;
    if (rd_req) dx_d = bh ? rd_cnt[CW-1:DW] : rd_cnt[DW-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dx_q <= '0;
      dv_q <= 1'b0;
    end else begin
      dx_q <= dx_d;
      dv_q <= rd_req;
    end
  end

  assign DX  = dx_q;
  assign dv  = dv_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_coinc_counter_bank.sv
// Bench for coinc_counter_bank: directed scenarios with fixed expectations, then random
// traffic checked cycle by cycle against an event-level reference model.
module tb_coinc_counter_bank;

  // Narrow words keep counter wrap reachable in a few hundred pulses.
  localparam int unsigned DW  = 4;
  localparam int unsigned WIN = 4;
  localparam int unsigned CW  = 2 * DW;

  logic          CLK = 1'b0;
  logic          RST, PA, PB, cea, ceb, bh, bl, ocx, ocy;
  logic [DW-1:0] DX;
  logic          dv;
  logic [2:0]    ovf;

  int n_tests = 0;
  int n_fail  = 0;

  coinc_counter_bank #(.DW(DW), .WIN(WIN)) dut (
    .CLK(CLK), .RST(RST), .PA(PA), .PB(PB), .cea(cea), .ceb(ceb), .bh(bh), .bl(bl),
    .ocx(ocx), .ocy(ocy), .DX(DX), .dv(dv), .ovf(ovf)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // Reference model: pin samples become counted edges two clocks later; coincidences are
  // judged by the cycle distance between an unmatched edge and its partner.
  logic [CW-1:0] m_live [3];
  logic [CW-1:0] m_sh   [3];
  logic [2:0]    m_ovf;
  logic [DW-1:0] m_dx;
  logic          m_dv;
  logic [2:0]    pa_hist, pb_hist;
  int            pend, pend_t, cyc;

  initial begin
    cyc = 0;
    pend = 0;
    pend_t = 0;
  end

  always @(posedge CLK) begin
    logic       ea, eb, sel;
    logic [2:0] inc;
    int         idx;
    cyc++;
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        m_live[i] = '0;
        m_sh[i]   = '0;
      end
      m_ovf = '0; m_dx = '0; m_dv = 1'b0;
      pa_hist = '0; pb_hist = '0; pend = 0;
    end else begin
      ea = pa_hist[1] && !pa_hist[2];
      eb = pb_hist[1] && !pb_hist[2];
      pa_hist = {pa_hist[1:0], PA};
      pb_hist = {pb_hist[1:0], PB};
      sel  = (cea || ceb) && (bh != bl);
      idx  = (cea && ceb) ? 2 : (cea ? 0 : 1);
      m_dv = sel;
      m_dx = sel ? (bh ? m_sh[idx][CW-1:DW] : m_sh[idx][DW-1:0]) : '0;
      if (ocx) for (int i = 0; i < 3; i++) m_sh[i] = m_live[i];
      if (ocy) begin
        for (int i = 0; i < 3; i++) m_live[i] = '0;
        m_ovf = '0;
        pend  = 0;
      end else begin
        if (pend != 0 && (cyc - pend_t) > int'(WIN)) pend = 0;
        inc = {1'b0, eb, ea};
        case (pend)
          0: begin
            if (ea && eb) inc[2] = 1'b1;
            else if (ea) begin pend = 1; pend_t = cyc; end
            else if (eb) begin pend = 2; pend_t = cyc; end
          end
          1: begin
            if (eb) begin inc[2] = 1'b1; pend = 0; end
            else if (ea) pend_t = cyc;
          end
          default: begin
            if (ea) begin inc[2] = 1'b1; pend = 0; end
            else if (eb) pend_t = cyc;
          end
        endcase
        for (int i = 0; i < 3; i++) begin
          if (inc[i]) begin
            if (m_live[i] == '1) m_ovf[i] = 1'b1;
            m_live[i] = m_live[i] + {{(CW - 1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    PA = 0; PB = 0; cea = 0; ceb = 0; bh = 0; bl = 0; ocx = 0; ocy = 0;
  endtask

  task automatic pulse(input logic a, input logic b, input int n);
    repeat (n) begin
      PA = a; PB = b; tick();
      PA = 0; PB = 0; tick();
    end
  endtask

  task automatic snap();
    ocx = 1; tick(); ocx = 0;
  endtask

  task automatic clear();
    ocy = 1; tick(); ocy = 0;
  endtask

  task automatic read_word(input logic a, input logic b, input logic hi,
                           output logic [DW-1:0] d, output logic v);
    cea = a; ceb = b; bh = hi; bl = !hi;
    tick();
    d = DX; v = dv;
    cea = 0; ceb = 0; bh = 0; bl = 0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    logic          v;
    idle_inputs();
    RST = 1; PA = 1; tick(); tick();
    RST = 0; PA = 0;
    n_tests++;
    if (DX !== '0 || dv !== 1'b0) begin
      n_fail++; $display("FAIL reset_out: DX=%h dv=%b, required 0/0", DX, dv);
    end
    n_tests++;
    if (ovf !== 3'b000) begin n_fail++; $display("FAIL reset_ovf: ovf=%b, required 000", ovf); end
    tick(); tick(); tick();
    snap();
    read_word(1, 0, 0, d, v);
    n_tests++;
    if (d !== '0 || v !== 1'b1) begin
      n_fail++; $display("FAIL reset_cnt_a: DX=%h dv=%b, required 0/1", d, v);
    end
  endtask

  task automatic test_count_read();
    logic [DW-1:0] d;
    logic          v;
    clear();
    pulse(1, 0, 5);
    tick(); tick(); tick();
    snap();
    read_word(1, 0, 0, d, v);
    n_tests++;
    if (d !== 4'd5 || v !== 1'b1) begin
      n_fail++; $display("FAIL count5_lo: DX=%h dv=%b, required 5/1", d, v);
    end
    read_word(1, 0, 1, d, v);
    n_tests++;
    if (d !== 4'd0 || v !== 1'b1) begin
      n_fail++; $display("FAIL count5_hi: DX=%h dv=%b, required 0/1", d, v);
    end
    tick();
    n_tests++;
    if (DX !== '0 || dv !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_read: DX=%h dv=%b, required 0/0", DX, dv);
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] d;
    logic          v;
    clear();
    PA = 1; tick(); PA = 0; tick();
    snap();  // third edge after the pin rose: shadow still sees the old count
    read_word(1, 0, 0, d, v);
    n_tests++;
    if (d !== 4'd0) begin n_fail++; $display("FAIL latency_early: DX=%h, required 0", d); end
    snap();
    read_word(1, 0, 0, d, v);
    n_tests++;
    if (d !== 4'd1) begin n_fail++; $display("FAIL latency_late: DX=%h, required 1", d); end
    clear();
    PB = 1; repeat (6) tick(); PB = 0;
    tick(); tick(); tick();
    snap();
    read_word(0, 1, 0, d, v);
    n_tests++;
    if (d !== 4'd1 || v !== 1'b1) begin
      n_fail++; $display("FAIL level_once: DX=%h dv=%b, required 1/1", d, v);
    end
  endtask

  task automatic test_coinc();
    logic [7:0]    pa_pat [9];
    logic [7:0]    pb_pat [9];
    logic [DW-1:0] ea [9];
    logic [DW-1:0] eb [9];
    logic [DW-1:0] ec [9];
    logic [DW-1:0] d;
    logic          v;
    pa_pat = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h04, 8'h09, 8'h01};
    pb_pat = '{8'h08, 8'h40, 8'h01, 8'h05, 8'h10, 8'h20, 8'h01, 8'h80, 8'h14};
    ea     = '{4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd1,  4'd2,  4'd1};
    eb     = '{4'd1,  4'd1,  4'd1,  4'd2,  4'd1,  4'd1,  4'd1,  4'd1,  4'd2};
    ec     = '{4'd1,  4'd0,  4'd1,  4'd1,  4'd1,  4'd0,  4'd1,  4'd1,  4'd1};
    for (int k = 0; k < 9; k++) begin
      clear();
      for (int i = 0; i < 8; i++) begin
        PA = pa_pat[k][i]; PB = pb_pat[k][i]; tick();
      end
      PA = 0; PB = 0;
      repeat (WIN + 4) tick();
      snap();
      read_word(1, 0, 0, d, v);
      n_tests++;
      if (d !== ea[k]) begin n_fail++; $display("FAIL coinc%0d_a: A=%h, required %h", k, d, ea[k]); end
      read_word(0, 1, 0, d, v);
      n_tests++;
      if (d !== eb[k]) begin n_fail++; $display("FAIL coinc%0d_b: B=%h, required %h", k, d, eb[k]); end
      read_word(1, 1, 0, d, v);
      n_tests++;
      if (d !== ec[k] || v !== 1'b1) begin
        n_fail++; $display("FAIL coinc%0d_c: C=%h dv=%b, required %h/1", k, d, v, ec[k]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d, d2;
    logic          v;
    clear();
    pulse(1, 1, 255);
    repeat (WIN + 4) tick();
    n_tests++;
    if (ovf !== 3'b000) begin n_fail++; $display("FAIL wrap_pre: ovf=%b, required 000", ovf); end
    snap();
    read_word(1, 1, 1, d, v);
    read_word(1, 1, 0, d2, v);
    n_tests++;
    if ({d, d2} !== 8'hFF) begin
      n_fail++; $display("FAIL wrap_c_max: C=%h%h, required ff", d, d2);
    end
    pulse(1, 0, 1);
    repeat (WIN + 4) tick();
    n_tests++;
    if (ovf !== 3'b001) begin n_fail++; $display("FAIL wrap_a: ovf=%b, required 001", ovf); end
    pulse(0, 1, 1);
    repeat (WIN + 4) tick();
    n_tests++;
    if (ovf !== 3'b011) begin n_fail++; $display("FAIL wrap_b: ovf=%b, required 011", ovf); end
    pulse(1, 1, 1);
    repeat (WIN + 4) tick();
    n_tests++;
    if (ovf !== 3'b111) begin n_fail++; $display("FAIL wrap_c: ovf=%b, required 111", ovf); end
    snap();
    read_word(1, 0, 0, d, v);
    n_tests++;
    if (d !== 4'd1) begin n_fail++; $display("FAIL wrap_a_val: A=%h, required 1", d); end
    read_word(1, 1, 1, d, v);
    read_word(1, 1, 0, d2, v);
    n_tests++;
    if ({d, d2} !== 8'h00) begin
      n_fail++; $display("FAIL wrap_c_val: C=%h%h, required 00", d, d2);
    end
    clear();
    n_tests++;
    if (ovf !== 3'b000) begin n_fail++; $display("FAIL ovf_clear: ovf=%b, required 000", ovf); end
  endtask

  task automatic test_capture_clear();
    logic [DW-1:0] d;
    logic          v;
    clear();
    pulse(1, 0, 7);
    tick(); tick(); tick();
    PA = 1; tick(); PA = 0; tick();
    ocx = 1; ocy = 1; tick(); ocx = 0; ocy = 0;  // pending A edge lands on this edge
    read_word(1, 0, 0, d, v);
    n_tests++;
    if (d !== 4'd7) begin n_fail++; $display("FAIL capclr_shadow: A=%h, required 7", d); end
    tick(); tick(); tick();
    snap();
    read_word(1, 0, 0, d, v);
    n_tests++;
    if (d !== 4'd0) begin n_fail++; $display("FAIL capclr_live: A=%h, required 0", d); end
  endtask

  task automatic test_bad_select();
    logic [DW-1:0] d;
    logic          v;
    clear();
    pulse(1, 0, 3);
    tick(); tick(); tick();
    snap();
    read_word(1, 0, 0, d, v);
    n_tests++;
    if (d !== 4'd3 || v !== 1'b1) begin
      n_fail++; $display("FAIL sel_ok: DX=%h dv=%b, required 3/1", d, v);
    end
    cea = 1; bh = 1; bl = 1; tick();
    n_tests++;
    if (DX !== '0 || dv !== 1'b0) begin
      n_fail++; $display("FAIL sel_both: DX=%h dv=%b, required 0/0", DX, dv);
    end
    bh = 0; tick();
    n_tests++;
    if (DX !== 4'd3 || dv !== 1'b1) begin
      n_fail++; $display("FAIL sel_recover: DX=%h dv=%b, required 3/1", DX, dv);
    end
    cea = 0; tick();
    n_tests++;
    if (DX !== '0 || dv !== 1'b0) begin
      n_fail++; $display("FAIL sel_no_ce: DX=%h dv=%b, required 0/0", DX, dv);
    end
    cea = 1; RST = 1; tick(); RST = 0;
    n_tests++;
    if (DX !== '0 || dv !== 1'b0) begin
      n_fail++; $display("FAIL rst_read: DX=%h dv=%b, required 0/0", DX, dv);
    end
    tick();
    n_tests++;
    if (DX !== '0 || dv !== 1'b1) begin
      n_fail++; $display("FAIL rst_shadow: DX=%h dv=%b, required 0/1", DX, dv);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic          rc_a [5];
    logic          rc_b [5];
    logic          rc_h [5];
    logic [DW-1:0] exp_d [5];
    clear();
    pulse(1, 1, 2);
    repeat (WIN + 4) tick();
    pulse(1, 0, 1);
    repeat (WIN + 4) tick();
    snap();
    rc_a  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    rc_b  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    rc_h  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_d = '{4'd3, 4'd2, 4'd2, 4'd0, 4'd3};
    for (int i = 0; i < 5; i++) begin
      cea = rc_a[i]; ceb = rc_b[i]; bh = rc_h[i]; bl = !rc_h[i];
      tick();
      n_tests++;
      if (DX !== exp_d[i] || dv !== 1'b1) begin
        n_fail++; $display("FAIL b2b%0d: DX=%h dv=%b, required %h/1", i, DX, dv, exp_d[i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    clear();
    for (int i = 0; i < 1500; i++) begin
      PA  = ($urandom_range(0, 3) == 0);
      PB  = ($urandom_range(0, 3) == 0);
      ocx = ($urandom_range(0, 7) == 0);
      ocy = ($urandom_range(0, 399) == 0);
      cea = 1'($urandom_range(0, 1));
      ceb = 1'($urandom_range(0, 1));
      bh  = 1'($urandom_range(0, 1));
      bl  = 1'($urandom_range(0, 1));
      RST = ($urandom_range(0, 699) == 0);
      tick();
      n_tests++;
      if (DX !== m_dx || dv !== m_dv || ovf !== m_ovf) begin
        n_fail++;
        $display("FAIL rand%0d: DX=%h dv=%b ovf=%b, required %h/%b/%b",
                 i, DX, dv, ovf, m_dx, m_dv, m_ovf);
      end
    end
    RST = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    test_reset();
    test_count_read();
    test_latency();
    test_coinc();
    test_wrap();
    test_capture_clear();
    test_bad_select();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
